// File: rtl/sound_fx_pkg.sv
// Shared types and default timing constants for the sound effect block.
// Defaults assume a 25 MHz game clock.
package sound_fx_pkg;

  localparam int HALF_W = 16;
  localparam int DUR_W  = 22;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TONE1 = 2'd1,
    ST_TONE2 = 2'd2
  } state_t;

  localparam logic [HALF_W-1:0] TONE1_HALF_DEF = 16'd14205;
  localparam logic [HALF_W-1:0] TONE2_HALF_DEF = 16'd28409;
  localparam logic [DUR_W-1:0]  DUR_CYCLES_DEF = 22'd2500000;

  function automatic logic [HALF_W-1:0] half_for(input state_t st,
                                                 input logic [HALF_W-1:0] h1,
                                                 input logic [HALF_W-1:0] h2);
    return (st == ST_TONE2) ? h2 : h1;
  endfunction

endpackage

// File: rtl/sound_fx_if.sv
// Hit strobes in, tone status and speaker out; mute exists only with SOUND_FX_MUTE_EN.
// Master is the game side, slave is sound_fx.
interface sound_fx_if;

  logic       play_sound1;
  logic       play_sound2;
  logic       speaker;
  logic       busy;
  logic [1:0] tone_id;
`ifdef SOUND_FX_MUTE_EN
  logic       mute;
`endif

  modport master (
    output play_sound1,
    output play_sound2,
`ifdef SOUND_FX_MUTE_EN
    output mute,
`endif
    input  speaker,
    input  busy,
    input  tone_id
  );

  modport slave (
    input  play_sound1,
    input  play_sound2,
`ifdef SOUND_FX_MUTE_EN
    input  mute,
`endif
    output speaker,
    output busy,
    output tone_id
  );

endinterface

// File: rtl/sound_fx_square_wave_gen.sv
// Square wave with programmable half-period; restart forces high with phase zero, disable forces low.
// Latency 1 cycle from restart/enable to wave_out; no backpressure.
module square_wave_gen
  import sound_fx_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              enable,
  input  logic [HALF_W-1:0] half_period,
  output logic              wave_out
);

  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic              wave_q, wave_d;
  logic              last;

  always_comb begin
    // Half-periods of 0 or 1 both mean toggle every cycle.
    last   = (half_period <= HALF_W'(1)) || (cnt_q == half_period - HALF_W'(1));
    cnt_d  = cnt_q;
    wave_d = wave_q;
    if (restart) begin
      cnt_d  = '0;
      wave_d = 1'b1;
    end else if (!enable) begin
      cnt_d  = '0;
      wave_d = 1'b0;
    end else if (last) begin
      cnt_d  = '0;
      wave_d = ~wave_q;
    end else begin
      cnt_d  = cnt_q + HALF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wave_q <= wave_d;
    end
  end

  assign wave_out = wave_q;

endmodule

// File: rtl/sound_fx.sv
// Turns hit strobe rising edges into fixed-length tones (paddle beats brick); optional mute via SOUND_FX_MUTE_EN.
// Latency 1 cycle from strobe rise to speaker/busy/tone_id; no backpressure, unwanted rises are dropped.
module sound_fx
  import sound_fx_pkg::*;
#(
  parameter logic [HALF_W-1:0] TONE1_HALF = TONE1_HALF_DEF,
  parameter logic [HALF_W-1:0] TONE2_HALF = TONE2_HALF_DEF,
  parameter logic [DUR_W-1:0]  DUR_CYCLES = DUR_CYCLES_DEF
)(
  input  logic      clk,
  input  logic      reset,
  sound_fx_if.slave bus
);

  state_t            state_q, state_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic              busy_q, busy_d;
  logic              prev1_q, prev2_q;
  logic              rise1, rise2;
  logic              restart;
  logic              speaker_q;
  logic [HALF_W-1:0] half_period;

  always_comb begin
    rise1   = bus.play_sound1 & ~prev1_q;
    rise2   = bus.play_sound2 & ~prev2_q;
    state_d = state_q;
    dur_d   = dur_q;
    restart = 1'b0;
    if (rise2) begin
      dur_d = '0;
      if (state_q != ST_TONE2) begin
        state_d = ST_TONE2;
        restart = 1'b1;
      end
    end else if (rise1 && state_q != ST_TONE2) begin
      // A brick hit during its own tone only extends it; the wave phase is kept.
      dur_d = '0;
      if (state_q == ST_IDLE) begin
        state_d = ST_TONE1;
        restart = 1'b1;
      end
    end else if (state_q != ST_IDLE) begin
      if (dur_q == DUR_CYCLES - DUR_W'(1)) begin
        state_d = ST_IDLE;
        dur_d   = '0;
      end else begin
        dur_d   = dur_q + DUR_W'(1);
      end
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dur_q   <= '0;
      busy_q  <= 1'b0;
      prev1_q <= 1'b0;
      prev2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      busy_q  <= busy_d;
      prev1_q <= bus.play_sound1;
      prev2_q <= bus.play_sound2;
    end
  end

  assign half_period = half_for(state_q, TONE1_HALF, TONE2_HALF);

  square_wave_gen u_wave (
    .clk         (clk),
    .reset       (reset),
    .restart     (restart),
    .enable      (busy_d),
    .half_period (half_period),
    .wave_out    (speaker_q)
  );

  assign bus.busy    = busy_q;
  assign bus.tone_id = state_q;

`ifdef SOUND_FX_MUTE_EN
  // Mute gates only the pin so unmuting resumes the running phase.
  assign bus.speaker = speaker_q & ~bus.mute;
`else
  assign bus.speaker = speaker_q;
`endif

endmodule

// File: tb/tb_sound_fx.sv
// Bench for sound_fx with short tones (halves 4 and 8, duration 40) against a timeline-based model.
module tb_sound_fx;

  localparam int T1  = 4;
  localparam int T2  = 8;
  localparam int DUR = 40;

  logic clk = 1'b0;
  logic reset;
  sound_fx_if bus();

  sound_fx #(
    .TONE1_HALF (16'd4),
    .TONE2_HALF (16'd8),
    .DUR_CYCLES (22'd40)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: a tone is described by when its wave started and its last busy cycle.
  int k = 0;
  int m_tone = 0;
  int m_phase0 = 0;
  int m_end = 0;
  bit m_prev1 = 1'b0;
  bit m_prev2 = 1'b0;

  logic       spk, bsy;
  logic [1:0] tid;

  task automatic model_edge(input bit r, input bit p1, input bit p2);
    bit r1, r2;
    k++;
    r1 = p1 && !m_prev1;
    r2 = p2 && !m_prev2;
    if (r) begin
      m_tone = 0;
      m_prev1 = 1'b0;
      m_prev2 = 1'b0;
      return;
    end
    m_prev1 = p1;
    m_prev2 = p2;
    if (r2) begin
      if (m_tone != 2) m_phase0 = k;
      m_tone = 2;
      m_end  = k + DUR - 1;
    end else if (r1 && m_tone != 2) begin
      if (m_tone == 0) m_phase0 = k;
      m_tone = 1;
      m_end  = k + DUR - 1;
    end
    if (m_tone != 0 && k > m_end) m_tone = 0;
  endtask

  function automatic bit model_speaker();
    int h;
    if (m_tone == 0) return 1'b0;
    h = (m_tone == 1) ? T1 : T2;
    if (h < 1) h = 1;
    return ((k - m_phase0) / h) % 2 == 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit p1, input bit p2);
    bit es, eb;
    int et;
    @(negedge clk);
    reset = r;
    bus.play_sound1 = p1;
    bus.play_sound2 = p2;
    @(posedge clk);
    model_edge(r, p1, p2);
    #1;
    spk = bus.speaker;
    bsy = bus.busy;
    tid = bus.tone_id;
    es = model_speaker();
    eb = (m_tone != 0);
    et = m_tone;
    checks++;
    if (spk !== es || bsy !== eb || tid !== 2'(et)) begin
      errors++;
      $display("FAIL model cycle %0d: spk/busy/tone=%0b/%0b/%0d expected %0b/%0b/%0d",
               k, spk, bsy, tid, es, eb, et);
    end
  endtask

  typedef struct {
    bit       r, p1, p2;
    bit       spk, busy;
    int       tid;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int nb, ntr, nrise;
    bit last, lastb;
    bit rp1;
    reset = 1'b1;
    bus.play_sound1 = 1'b0;
    bus.play_sound2 = 1'b0;
`ifdef SOUND_FX_MUTE_EN
    bus.mute = 1'b0;
`endif

    vecs[0]  = '{1,0,0, 0,0,0};
    vecs[1]  = '{1,0,0, 0,0,0};
    vecs[2]  = '{1,0,0, 0,0,0};
    vecs[3]  = '{0,0,0, 0,0,0};
    vecs[4]  = '{0,1,0, 1,1,1};
    vecs[5]  = '{0,0,0, 1,1,1};
    vecs[6]  = '{0,0,0, 1,1,1};
    vecs[7]  = '{0,0,0, 1,1,1};
    vecs[8]  = '{0,0,0, 0,1,1};
    vecs[9]  = '{0,0,1, 1,1,2};
    vecs[10] = '{0,1,0, 1,1,2};
    vecs[11] = '{0,1,0, 1,1,2};
    vecs[12] = '{1,1,0, 0,0,0};
    vecs[13] = '{0,1,1, 1,1,2};
    vecs[14] = '{0,0,0, 1,1,2};

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].r, vecs[i].p1, vecs[i].p2);
      checks++;
      if (spk !== vecs[i].spk || bsy !== vecs[i].busy || tid !== 2'(vecs[i].tid)) begin
        errors++;
        $display("FAIL vec%0d: spk/busy/tone=%0b/%0b/%0d expected %0b/%0b/%0d",
                 i, spk, bsy, tid, vecs[i].spk, vecs[i].busy, vecs[i].tid);
      end
    end

    // Reset 3, idle 10, then a single brick pulse.
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0);
      if (bsy || spk || tid != 0) nb++;
    end
    chk("idle_quiet", nb, 0);
    nb = 0;
    for (int c = 0; c < 60; c++) begin
      step(0, c == 0, 0);
      if (c == 0) chk("pulse_first_speaker", spk, 1);
      if (bsy) nb++;
    end
    chk("pulse_busy_len", nb, 40);

    // Held level gives exactly one tone.
    for (int i = 0; i < 2; i++) step(1, 0, 0);
    nb = 0; nrise = 0; lastb = 1'b0;
    for (int c = 0; c < 110; c++) begin
      step(0, c < 100, 0);
      if (bsy) nb++;
      if (bsy && !lastb) nrise++;
      lastb = bsy;
    end
    chk("held_busy_len", nb, 40);
    chk("held_tone_count", nrise, 1);

    // Simultaneous rises: paddle wins.
    for (int i = 0; i < 2; i++) step(1, 0, 0);
    nb = 0;
    for (int c = 0; c < 50; c++) begin
      step(0, c == 0, c == 0);
      if (c == 0) chk("simul_tone_id", tid, 2);
      if (bsy) nb++;
    end
    chk("simul_busy_len", nb, 40);

    // Paddle preempts brick.
    for (int i = 0; i < 2; i++) step(1, 0, 0);
    nb = 0;
    for (int c = 0; c < 60; c++) begin
      step(0, c == 0, c == 10);
      if (c == 9)  chk("preempt_before_id", tid, 1);
      if (c == 10) chk("preempt_tone_id", tid, 2);
      if (c == 49) chk("preempt_busy_end", bsy, 1);
      if (c == 50) chk("preempt_idle", bsy, 0);
      if (bsy) nb++;
    end
    chk("preempt_busy_len", nb, 50);

    // Brick retrigger extends without a phase glitch.
    for (int i = 0; i < 2; i++) step(1, 0, 0);
    nb = 0; ntr = 0; last = 1'b0;
    for (int c = 0; c < 80; c++) begin
      step(0, (c == 0) || (c == 30), 0);
      if (c >= 1 && c <= 70 && spk != last) ntr++;
      last = spk;
      if (c == 69) chk("retrig_busy_end", bsy, 1);
      if (c == 70) chk("retrig_idle", bsy, 0);
      if (bsy) nb++;
    end
    chk("retrig_busy_len", nb, 70);
    chk("retrig_speaker_edges", ntr, 17);

    // Reset mid-tone, then a clean paddle start.
    for (int i = 0; i < 2; i++) step(1, 0, 0);
    for (int c = 0; c < 30; c++) begin
      step(c == 15, c == 0, c == 20);
      if (c == 15) chk("midreset_speaker", spk, 0);
      if (c == 15) chk("midreset_busy", bsy, 0);
      if (c == 20) chk("after_reset_speaker", spk, 1);
      if (c == 20) chk("after_reset_tone", tid, 2);
    end

    // Random toggling levels with occasional reset.
    rp1 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit rr, rp2;
      rr = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 14) == 0) rp1 = ~rp1;
      rp2 = bus.play_sound2;
      if ($urandom_range(0, 29) == 0) rp2 = ~rp2;
      step(rr, rp1, rp2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
